// File: rtl/serial_add.sv
// rtl/serial_add.sv - multi-cycle add/subtract unit summing BITS_PER_CYCLE bits per clock
module serial_add #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int BPC    = BITS_PER_CYCLE;
    localparam int CYCLES = WIDTH / BPC;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    generate
        if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
            $error("serial_add: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;

    // Operands shift right by one slice per RUN cycle, so the active slice
    // is always the low BPC bits; the result shifts in from the top and is
    // fully aligned after the final slice.
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             cout_r;
    logic             ovf_r;

    logic [BPC-1:0]   slice_a;
    logic [BPC-1:0]   slice_b;
    logic [BPC-1:0]   slice_s;
    logic             slice_c;
    logic             c_into_msb;

    assign last     = (count == CNT_W'(CYCLES - 1));
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = ovf_r;

    // Ripple slice: adds the current operand slice plus the inter-cycle carry.
    // The carry into the top bit of the slice is recovered from that bit's
    // sum and inputs, which gives the carry into the MSB on the final slice.
    always_comb begin
        slice_a              = opa[BPC-1:0];
        slice_b              = opb[BPC-1:0];
        {slice_c, slice_s}   = {1'b0, slice_a} + {1'b0, slice_b} + {{BPC{1'b0}}, carry};
        c_into_msb           = slice_s[BPC-1] ^ slice_a[BPC-1] ^ slice_b[BPC-1];
    end

    // State register; reset overrides any start on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, one slice per RUN cycle, flags on the last slice.
    // Subtraction is a + ~b + ~borrow, so carry-out reads as "no borrow".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            count  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            count <= '0;
        end else if (state == S_RUN) begin
            opa   <= opa >> BPC;
            opb   <= opb >> BPC;
            sum_r <= (sum_r >> BPC) | (WIDTH'(slice_s) << (WIDTH - BPC));
            carry <= slice_c;
            if (last) begin
                count  <= '0;
                cout_r <= slice_c;
                ovf_r  <= slice_c ^ c_into_msb;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule
